// File: rtl/axis_bist_pkt_gen_pkg.sv
// Shared definitions for the BIST packet generator and its future checker:
// register offsets, pattern/state encodings and the payload LFSR.
package bist_pkg;

  localparam int REG_CTRL = 0;
  localparam int REG_CFG  = 1;
  localparam int REG_GAP  = 2;
  localparam int REG_SID  = 3;

  typedef enum logic [1:0] {
    PAT_ZERO = 2'd0,
    PAT_ONES = 2'd1,
    PAT_RAMP = 2'd2,
    PAT_PRBS = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Fibonacci taps 64,63,61,60 map to bits 63,62,60,59.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr64_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_bist_pkt_gen_if.sv
// 64-bit AXI-Stream link out of the BIST generator.
// A beat transfers on a rising clk edge where tvalid && tready; once tvalid
// is high the source holds tdata/tlast/tvalid unchanged until that transfer.
interface axis_bist_pkt_gen_if;
  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_bist_pkt_gen_pattern_src.sv
// Payload word source: the current word is presented on o_word; i_init
// reseeds at run start and i_adv steps to the next word after it is used.
module bist_pattern_src
  import bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_adv,
  input  pattern_e    i_pat,
  input  logic [31:0] i_sid,
  output logic [63:0] o_word
);

  logic [63:0] r_cnt;
  logic [63:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_lfsr <= '0;
    end else if (i_init) begin
      r_cnt  <= '0;
      r_lfsr <= {i_sid, ~i_sid};
    end else if (i_adv) begin
      r_cnt  <= r_cnt + 64'd1;
      r_lfsr <= lfsr64_next(r_lfsr);
    end
  end

  always_comb begin
    o_word = '0;
    case (i_pat)
      PAT_ZERO: o_word = '0;
      PAT_ONES: o_word = '1;
      PAT_RAMP: o_word = r_cnt;
      PAT_PRBS: o_word = r_lfsr;
      default:  o_word = '0;
    endcase
  end

endmodule

// File: rtl/axis_bist_pkt_gen.sv
// CVITA-framed BIST packet generator: settings-bus programmed length, count,
// payload pattern and inter-packet gap, emitted over a 64-bit AXI-Stream.
module axis_bist_pkt_gen
  import bist_pkg::*;
#(
  parameter int SR_BASE   = 0,
  parameter int SR_AWIDTH = 8,
  parameter int SR_DWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_stb,
  input  logic [SR_AWIDTH-1:0] set_addr,
  input  logic [SR_DWIDTH-1:0] set_data,
  axis_bist_pkt_gen_if.master  m_axis,
  output logic                 running,
  output logic                 done,
  output logic [31:0]          pkt_cnt,
  output state_e               o_dbg_state
);

  localparam logic [SR_AWIDTH-1:0] A_CTRL = SR_AWIDTH'(SR_BASE + REG_CTRL);
  localparam logic [SR_AWIDTH-1:0] A_CFG  = SR_AWIDTH'(SR_BASE + REG_CFG);
  localparam logic [SR_AWIDTH-1:0] A_GAP  = SR_AWIDTH'(SR_BASE + REG_GAP);
  localparam logic [SR_AWIDTH-1:0] A_SID  = SR_AWIDTH'(SR_BASE + REG_SID);

  // Shadow registers written by the bus; copied into run registers on go.
  logic        r_sh_ramp;
  logic [9:0]  r_sh_nwords;
  logic [17:0] r_sh_num;
  logic [7:0]  r_sh_gap;
  logic [31:0] r_sh_sid;

  logic        r_ramp, r_cont, r_stop_req;
  logic [9:0]  r_nmax, r_cur_n, r_word_idx;
  logic [17:0] r_num_pkts;
  logic [7:0]  r_gap, r_gap_cnt;
  logic [31:0] r_sid, r_pkt_cnt;
  logic [11:0] r_seq;
  pattern_e    r_pat;
  state_e      r_state, w_next;

  logic        w_ctrl_wr, w_start, w_halt, w_beat, w_last_word, w_pkt_end, w_cnt_reached;
  logic [9:0]  w_sh_nmax;
  logic [15:0] w_len;
  logic [63:0] w_pat_word;

  assign w_ctrl_wr     = set_stb && (set_addr == A_CTRL);
  assign w_start       = w_ctrl_wr && set_data[0] && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_halt        = w_ctrl_wr && !set_data[0];
  assign w_beat        = m_axis.tvalid && m_axis.tready;
  assign w_last_word   = (r_word_idx == r_cur_n);
  assign w_pkt_end     = (r_state == ST_DATA) && w_beat && w_last_word;
  assign w_cnt_reached = !r_cont && ((r_pkt_cnt + 32'd1) == {14'd0, r_num_pkts});
  assign w_sh_nmax     = (r_sh_nwords == 10'd0) ? 10'd1 : r_sh_nwords;
  assign w_len         = 16'({r_cur_n, 3'b000}) + 16'd8;

  bist_pattern_src u_pat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_init (w_start),
    .i_adv  ((r_state == ST_DATA) && w_beat),
    .i_pat  (r_pat),
    .i_sid  (r_sh_sid),
    .o_word (w_pat_word)
  );

  always_comb begin
    w_next        = r_state;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tdata  = '0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start)
          w_next = (!set_data[1] && r_sh_num == 18'd0) ? ST_DONE : ST_HDR;
        else if (w_halt)
          w_next = ST_IDLE;
      end
      ST_HDR: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = {2'b00, 1'b0, 1'b0, r_seq, w_len, r_sid};
        if (w_beat) w_next = ST_DATA;
      end
      ST_DATA: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = w_pat_word;
        m_axis.tlast  = w_last_word;
        if (w_pkt_end) begin
          if (r_stop_req || w_cnt_reached) w_next = ST_DONE;
          else if (r_gap == 8'd0)          w_next = ST_HDR;
          else                             w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_stop_req)              w_next = ST_DONE;
        else if (r_gap_cnt == 8'd0)  w_next = ST_HDR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sh_ramp  <= 1'b0;
      r_sh_nwords <= '0;
      r_sh_num   <= '0;
      r_sh_gap   <= '0;
      r_sh_sid   <= '0;
      r_ramp     <= 1'b0;
      r_cont     <= 1'b0;
      r_stop_req <= 1'b0;
      r_nmax     <= '0;
      r_cur_n    <= '0;
      r_word_idx <= '0;
      r_num_pkts <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_sid      <= '0;
      r_pkt_cnt  <= '0;
      r_seq      <= '0;
      r_pat      <= PAT_ZERO;
    end else begin
      r_state <= w_next;
      if (set_stb && set_addr == A_CFG) begin
        r_sh_ramp   <= set_data[31];
        r_sh_nwords <= set_data[30:21];
        r_sh_num    <= set_data[17:0];
      end
      if (set_stb && set_addr == A_GAP) r_sh_gap <= set_data[7:0];
      if (set_stb && set_addr == A_SID) r_sh_sid <= set_data[31:0];

      if (w_start) begin
        r_ramp     <= r_sh_ramp;
        r_nmax     <= w_sh_nmax;
        r_cur_n    <= r_sh_ramp ? 10'd1 : w_sh_nmax;
        r_num_pkts <= r_sh_num;
        r_gap      <= r_sh_gap;
        r_sid      <= r_sh_sid;
        r_cont     <= set_data[1];
        r_pat      <= pattern_e'(set_data[5:4]);
        r_word_idx <= 10'd1;
        r_seq      <= '0;
        r_pkt_cnt  <= '0;
        r_stop_req <= 1'b0;
      end else if (w_halt && running) begin
        r_stop_req <= 1'b1;
      end

      if ((r_state == ST_DATA) && w_beat) begin
        if (w_last_word) begin
          r_word_idx <= 10'd1;
          r_seq      <= r_seq + 12'd1;
          if (r_pkt_cnt != 32'hFFFF_FFFF) r_pkt_cnt <= r_pkt_cnt + 32'd1;
          if (r_ramp) r_cur_n <= (r_cur_n >= r_nmax) ? 10'd1 : r_cur_n + 10'd1;
        end else begin
          r_word_idx <= r_word_idx + 10'd1;
        end
      end

      // The GAP state lasts r_gap cycles: counter runs gap-1 down to 0.
      if (w_pkt_end)
        r_gap_cnt <= r_gap - 8'd1;
      else if (r_state == ST_GAP && r_gap_cnt != 8'd0)
        r_gap_cnt <= r_gap_cnt - 8'd1;
    end
  end

  assign running     = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_GAP);
  assign done        = (r_state == ST_DONE);
  assign pkt_cnt     = r_pkt_cnt;
  assign o_dbg_state = r_state;

endmodule
